wb_test_initiator: RTL and testbench
====================================

# wb_test_initiator

Wishbone classic single-transfer initiator for the gf180 test-structure user project; it drives the other end of the same 32-bit Wishbone interface the user project wrapper exposes as a responder. A simple valid/ready command port, driven by a logic-analyzer or GPIO sequencer, requests one read or write at a time. The block runs the bus cycle, enforces a no-ACK timeout, and returns the result on a valid/ready response port. It also keeps completed-transfer and error counters for characterisation runs.

## Interface
Parameters:
- TIMEOUT, 255: cycles with STB asserted and no ACK before a transfer is aborted; legal range 2..65535.

Ports:
- wb_clk_i  input  1  sole clock; all state updates on its rising edge
- wb_rst_i  input  1  reset, asynchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_we  input  1  1 = write, 0 = read
- cmd_adr  input  32  byte address
- cmd_dat  input  32  write data
- cmd_sel  input  4  byte selects
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rsp_dat  output  32  read data; 0 for writes and for errors
- rsp_err  output  1  1 = timeout abort
- wbm_cyc_o  output  1  Wishbone CYC
- wbm_stb_o  output  1  Wishbone STB
- wbm_we_o  output  1  Wishbone WE
- wbm_sel_o  output  4  Wishbone SEL
- wbm_adr_o  output  32  Wishbone ADR
- wbm_dat_o  output  32  Wishbone write data
- wbm_ack_i  input  1  Wishbone ACK
- wbm_dat_i  input  32  Wishbone read data
- txn_count  output  16  count of completed (ACKed) transfers
- err_count  output  8  count of timeouts

## Operation
- FSM states are IDLE, BUS and RESP.
- **IDLE:**
  - cmd_ready=1; every other control output is 0.
  - If cmd_valid=1 at an edge: register we, adr, dat and sel onto the wbm_* outputs, set cyc=stb=1, clear the timeout counter, and go to BUS.
- **BUS:**
  - cyc and stb stay high, and we, adr, dat and sel stay stable; cmd_ready=0.
  - The timeout counter increments on each edge without ACK.
  - ACK sampled high: cyc=stb=0 at that edge; capture rsp_dat (wbm_dat_i for a read, 0 for a write); rsp_err=0; increment txn_count, wrapping at 0xFFFF; go to RESP.
  - Counter reaches TIMEOUT-1 with ACK low: cyc=stb=0; rsp_dat=0; rsp_err=1; increment err_count, saturating at 0xFF; go to RESP.
  - ACK and timeout on the same edge: ACK wins, and the transfer counts as a success.
- **RESP:**
  - rsp_valid=1, with rsp_dat and rsp_err held stable; cmd_ready=0.
  - Any wbm_ack_i here is ignored.
  - rsp_ready=1 at an edge: rsp_valid=0 and go to IDLE.
- Only one transfer is ever outstanding. There are no bursts, no CTI/BTE and no ERR/RTY inputs.
- wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o keep their last values after a transfer ends. They are don't-care while cyc=0.

## Timing
- **Reset values:** every output is 0 except cmd_ready=1. State=IDLE; all counters 0.
- **Reset during BUS or RESP:** cyc and stb drop immediately without waiting for a clock edge. The in-flight response is discarded and no counter changes.
- **Command to bus:** cmd handshake at edge N → cyc and stb are high in the cycle after N.
- **Bus to response:** ACK sampled at edge M → cyc and stb are low and rsp_valid is high after M.
- **Zero-wait responder** (ACK combinational on STB): cmd handshake to rsp_valid is 2 edges.
- **Back-to-back transfers:** after the rsp handshake at edge K, cmd_ready=1 after K. The earliest next command accept is edge K+1, so the minimum period is 3 cycles per transfer.
- **Timeout:** STB stays high for exactly TIMEOUT cycles before the abort edge.
- cmd_* inputs are sampled only in IDLE. Changes at other times have no effect.

## Test plan
- Reset, then write adr=0x3000_0004, dat=0xA5A5_5A5A, sel=0xF with a zero-wait ACK → one-cycle STB with matching wbm_* values; rsp_valid after 2 edges with rsp_err=0 and rsp_dat=0; txn_count=1.
- Read adr=0x3000_0010, responder ACKs after 3 wait cycles with dat=0x1234_5678 → STB high for 4 cycles; rsp_dat=0x1234_5678; rsp_err=0.
- TIMEOUT=8, read with no ACK → STB high exactly 8 cycles then low; rsp_err=1; rsp_dat=0; err_count=1; txn_count unchanged.
- ACK asserted on exactly the timeout edge → success with rsp_err=0; txn_count increments; err_count unchanged.
- rsp_ready held low for 5 cycles, with an extra ACK and a cmd_valid pulse in RESP → rsp_valid and data stable for all 5 cycles; the pulse is ignored and no new bus cycle starts.
- Assert wb_rst_i mid-BUS → cyc and stb go low asynchronously with no edge needed; cmd_ready=1 and counters=0; then 300 timeouts → err_count saturates at 0xFF.

Source files
------------

// File: rtl/wb_test_initiator.sv
// wb_test_initiator: single-transfer Wishbone classic initiator with a valid/ready command/response port,
// a no-ACK timeout, and counters for completed transfers and timeouts.
module wb_test_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic [15:0] txn_count,
  output logic [7:0]  err_count
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_tmo;
  logic        w_start, w_ack, w_abort;
  assign w_start = r_state == IDLE && cmd_valid;
  assign w_ack   = r_state == BUS && wbm_ack_i;
  // ACK on the timeout edge takes priority, so abort requires ACK low
  assign w_abort = r_state == BUS && !wbm_ack_i && r_tmo == 16'(TIMEOUT - 1);
  always_comb begin
    w_next    = r_state;
    cmd_ready = r_state == IDLE;
    rsp_valid = r_state == RESP;
    wbm_cyc_o = r_state == BUS;
    wbm_stb_o = r_state == BUS;
    if (w_start) w_next = BUS;
    else if (w_ack || w_abort) w_next = RESP;
    else if (r_state == RESP && rsp_ready) w_next = IDLE;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_tmo     <= '0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      txn_count <= '0;
      err_count <= '0;
    end else begin
      if (w_start) begin
        wbm_we_o  <= cmd_we;
        wbm_sel_o <= cmd_sel;
        wbm_adr_o <= cmd_adr;
        wbm_dat_o <= cmd_dat;
        r_tmo     <= '0;
      end else if (r_state == BUS) r_tmo <= r_tmo + 16'd1;
      if (w_ack) begin
        rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
        rsp_err   <= 1'b0;
        txn_count <= txn_count + 16'd1;
      end else if (w_abort) begin
        rsp_dat   <= '0;
        rsp_err   <= 1'b1;
        err_count <= err_count == 8'hFF ? err_count : err_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_wb_test_initiator.sv
// tb_wb_test_initiator: directed and randomized transfers against a transaction-level model
// of the initiator, with a programmable-wait responder.
module tb_wb_test_initiator;
  localparam int T = 8;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [15:0] txn_count;
  logic [7:0]  err_count;
  int          wait_cnt = 0, delay = 0, n_vec = 0, n_err = 0, m_txn = 0, m_err = 0;
  logic        extra_ack = 1'b0;
  logic [31:0] rdata = '0;

  wb_test_initiator #(.TIMEOUT(T)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .txn_count(txn_count), .err_count(err_count)
  );

  always #5 clk = ~clk;
  // Responder: ACKs in the (delay+1)th STB cycle, combinationally when delay is 0
  always @(posedge clk) wait_cnt <= wbm_stb_o ? wait_cnt + 1 : 0;
  assign wbm_ack_i = extra_ack | (wbm_stb_o && wait_cnt == delay);
  assign wbm_dat_i = rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a falling edge; hold = cycles rsp_ready stays low in RESP
  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input int d, input int hold, input bit poke);
    bit          ok = d < T;
    int          exp_cyc = ok ? d + 1 : T;
    int          cyc_n = 0;
    bit          stable = 1;
    logic [31:0] exp_dat;
    rdata     = $urandom;
    exp_dat   = (ok && !we) ? rdata : 32'h0;
    delay     = d;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = ~sel;
    @(negedge clk);
    while (wbm_stb_o && cyc_n < 100) begin
      cyc_n++;
      if (wbm_adr_o !== adr || wbm_dat_o !== dat || wbm_we_o !== we || wbm_sel_o !== sel ||
          wbm_cyc_o !== 1'b1 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) stable = 0;
      @(negedge clk);
    end
    if (ok) m_txn++;
    else if (m_err < 255) m_err++;
    chk("stb_cycles", cyc_n, exp_cyc);
    chk("bus_stable", 32'(stable), 1);
    chk("rsp_valid", rsp_valid, 1);
    chk("cyc_low", wbm_cyc_o, 0);
    chk("rsp_dat", rsp_dat, exp_dat);
    chk("rsp_err", rsp_err, 32'(!ok));
    chk("txn_count", txn_count, 32'(m_txn & 16'hFFFF));
    chk("err_count", err_count, 32'(m_err));
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        extra_ack = i == 1;
        cmd_valid = i == 2;
      end
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_dat", rsp_dat, exp_dat);
      chk("hold_err", rsp_err, 32'(!ok));
      chk("hold_no_bus", {wbm_cyc_o, wbm_stb_o, cmd_ready}, 0);
      chk("hold_txn", txn_count, 32'(m_txn & 16'hFFFF));
    end
    extra_ack = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_rsp", {cmd_ready, rsp_valid, wbm_cyc_o}, 3'b100);
  endtask

  initial begin
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_ctrl", {rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
    chk("rst_bus", {wbm_sel_o, wbm_adr_o, wbm_dat_o}, 0);
    chk("rst_cnt", {txn_count, err_count}, 0);
    chk("rst_dat", rsp_dat, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    txn(1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, 0, 0, 0);
    txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 0, 0);
    txn(1'b0, 32'h3000_0020, 32'h0, 4'h3, 255, 0, 0);
    txn(1'b0, 32'h3000_0030, 32'h0, 4'h1, T - 1, 0, 0);
    txn(1'b0, 32'h3000_0040, 32'h0, 4'hC, 1, 5, 1);
    txn(1'b1, 32'h3000_0044, 32'hDEAD_BEEF, 4'h5, 0, 0, 0);
    txn(1'b0, 32'h3000_0048, 32'h0, 4'hF, 0, 0, 0);
    for (int k = 0; k < 40; k++)
      txn(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, T + 2)),
          int'($urandom_range(0, 3)), 1'($urandom));
    delay = 255;
    cmd_valid = 1'b1; cmd_we = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_bus_stb", wbm_stb_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_bus", {wbm_cyc_o, wbm_stb_o}, 0);
    chk("async_rst_ready", {cmd_ready, rsp_valid}, 2'b10);
    chk("async_rst_cnt", {txn_count, err_count}, 0);
    m_txn = 0; m_err = 0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 300; k++) txn(1'($urandom), $urandom, $urandom, 4'($urandom), 255, 0, 0);
    chk("err_saturated", err_count, 8'hFF);
    txn(1'b0, 32'h3000_0050, 32'h0, 4'hF, 2, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
